// File: rtl/native_mem_slave.sv
// native_mem_slave
//   Word-addressed memory slave on the picorv32 native memory interface.
//   Serves fetches, loads and byte-strobed stores after a fixed number of wait states.
//   Every store is also pushed into a write-log FIFO as an (address, data) pair.
//   Memory contents are not reset, so a preloaded program survives a reset pulse.
// Ports
//   clk, resetn          : clock, asynchronous active-low reset
//   mem_valid/ready      : request / one-cycle response pulse
//   mem_addr/wdata/wstrb : byte address, store data, byte-lane enables (0 = read)
//   mem_rdata            : read data, valid while mem_ready is high
//   init_we/addr/data    : preload port, usable in any state
//   log_valid/addr/data  : write-log head entry (first-word fall-through)
//   log_pop              : drop the head entry
//   log_count            : number of occupied log entries
//   log_overflow         : sticky, a store was dropped because the log was full
//   bus_err              : sticky, an out-of-range access occurred
module native_mem_slave #(
  parameter int unsigned MEM_WORDS   = 256,
  parameter int unsigned WAIT_CYCLES = 1,
  parameter int unsigned LOG_DEPTH   = 8   // power of two, at least 2
) (
  input  logic                         clk,
  input  logic                         resetn,
  input  logic                         mem_valid,
  output logic                         mem_ready,
  input  logic [31:0]                  mem_addr,
  input  logic [31:0]                  mem_wdata,
  input  logic [3:0]                   mem_wstrb,
  output logic [31:0]                  mem_rdata,
  input  logic                         init_we,
  input  logic [$clog2(MEM_WORDS)-1:0] init_addr,
  input  logic [31:0]                  init_data,
  output logic                         log_valid,
  output logic [31:0]                  log_addr,
  output logic [31:0]                  log_data,
  input  logic                         log_pop,
  output logic [$clog2(LOG_DEPTH):0]   log_count,
  output logic                         log_overflow,
  output logic                         bus_err
);

  localparam int unsigned AW = $clog2(MEM_WORDS);
  localparam int unsigned LW = $clog2(LOG_DEPTH);
  // Counter only ever holds WAIT_CYCLES-1.
  localparam int unsigned CW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  localparam logic [CW-1:0] WAIT_LOAD = CW'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);
  localparam logic [31:0]   ADDR_LIMIT = 32'(MEM_WORDS * 4);
  localparam logic [LW:0]   LOG_FULL   = (LW + 1)'(LOG_DEPTH);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  logic [1:0]    r_state;
  logic [CW-1:0] r_wait_cnt;
  logic [31:0]   r_addr;
  logic [31:0]   r_wdata;
  logic [3:0]    r_wstrb;
  logic [31:0]   r_mem [MEM_WORDS];

  logic [31:0]   r_log_addr [LOG_DEPTH];
  logic [31:0]   r_log_data [LOG_DEPTH];
  logic [LW-1:0] r_wr_ptr;
  logic [LW-1:0] r_rd_ptr;
  logic [LW:0]   r_count;
  logic          r_overflow;
  logic          r_bus_err;

  logic          w_resp;
  logic          w_in_range;
  logic [AW-1:0] w_idx;
  logic          w_store;
  logic          w_mem_we;
  logic          w_full;
  logic          w_pop;
  logic          w_push;

  assign w_resp     = (r_state == S_RESP);
  assign w_in_range = (r_addr < ADDR_LIMIT);
  assign w_idx      = r_addr[2 +: AW];
  assign w_store    = w_resp && (r_wstrb != 4'b0000);
  assign w_mem_we   = w_store && w_in_range;
  assign w_full     = (r_count == LOG_FULL);
  assign w_pop      = log_pop && (r_count != '0);
  // A full log still accepts the push when the head leaves on the same edge.
  assign w_push     = w_store && (!w_full || w_pop);

  // Request FSM
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state    <= S_IDLE;
      r_wait_cnt <= '0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_wstrb    <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (mem_valid) begin
            r_addr  <= mem_addr;
            r_wdata <= mem_wdata;
            r_wstrb <= mem_wstrb;
            if (WAIT_CYCLES == 0) begin
              r_state <= S_RESP;
            end else begin
              r_state    <= S_WAIT;
              r_wait_cnt <= WAIT_LOAD;
            end
          end
        end
        S_WAIT: begin
          if (r_wait_cnt == '0) begin
            r_state <= S_RESP;
          end else begin
            r_wait_cnt <= r_wait_cnt - 1'b1;
          end
        end
        S_RESP:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Storage array; the preload port is applied last so it wins over a same-word store.
  always_ff @(posedge clk) begin
    if (w_mem_we) begin
      for (int b = 0; b < 4; b++) begin
        if (r_wstrb[b]) r_mem[w_idx][8*b +: 8] <= r_wdata[8*b +: 8];
      end
    end
    if (init_we) r_mem[init_addr] <= init_data;
  end

  // Combinational read shows the pre-write contents during RESP.
  assign mem_ready = w_resp;
  assign mem_rdata = (w_resp && w_in_range) ? r_mem[w_idx] : 32'h0;

  // Write-log storage
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_log_addr[r_wr_ptr] <= r_addr;
      r_log_data[r_wr_ptr] <= r_wdata;
    end
  end

  // Write-log pointers and sticky flags
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
      r_bus_err  <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      if (w_store && !w_push)     r_overflow <= 1'b1;
      if (w_resp && !w_in_range)  r_bus_err  <= 1'b1;
    end
  end

  assign log_valid    = (r_count != '0);
  assign log_addr     = log_valid ? r_log_addr[r_rd_ptr] : 32'h0;
  assign log_data     = log_valid ? r_log_data[r_rd_ptr] : 32'h0;
  assign log_count    = r_count;
  assign log_overflow = r_overflow;
  assign bus_err      = r_bus_err;

endmodule

// File: tb/tb_native_mem_slave.sv
// tb_native_mem_slave
//   Drives native_mem_slave with directed and randomized accesses. A behavioural model
//   (word array, log queues, sticky flags) is updated at each response edge; a negedge
//   process compares the log and flag outputs to it every cycle, and the access task
//   checks response timing and read data.
module tb_native_mem_slave;

  localparam int unsigned MW = 256;
  localparam int unsigned W  = 1;
  localparam int unsigned LD = 8;

  logic        clk = 1'b0;
  logic        resetn;
  logic        mem_valid;
  logic        mem_ready;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_rdata;
  logic        init_we;
  logic [7:0]  init_addr;
  logic [31:0] init_data;
  logic        log_valid;
  logic [31:0] log_addr;
  logic [31:0] log_data;
  logic        log_pop;
  logic [3:0]  log_count;
  logic        log_overflow;
  logic        bus_err;

  native_mem_slave #(
    .MEM_WORDS  (MW),
    .WAIT_CYCLES(W),
    .LOG_DEPTH  (LD)
  ) dut (
    .clk         (clk),
    .resetn      (resetn),
    .mem_valid   (mem_valid),
    .mem_ready   (mem_ready),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_wstrb   (mem_wstrb),
    .mem_rdata   (mem_rdata),
    .init_we     (init_we),
    .init_addr   (init_addr),
    .init_data   (init_data),
    .log_valid   (log_valid),
    .log_addr    (log_addr),
    .log_data    (log_data),
    .log_pop     (log_pop),
    .log_count   (log_count),
    .log_overflow(log_overflow),
    .bus_err     (bus_err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Behavioural model
  logic [31:0] mem_m [MW];
  logic [31:0] qa [$];
  logic [31:0] qd [$];
  bit          ovf_m;
  bit          berr_m;
  bit          in_access;
  bit          cmp_en;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (cmp_en) begin
      check("log_count", 32'(log_count), 32'(qa.size()));
      check("log_valid", 32'(log_valid), (qa.size() != 0) ? 32'd1 : 32'd0);
      if (qa.size() != 0) begin
        check("log_addr", log_addr, qa[0]);
        check("log_data", log_data, qd[0]);
      end
      check("log_overflow", 32'(log_overflow), 32'(ovf_m));
      check("bus_err", 32'(bus_err), 32'(berr_m));
      if (!in_access) check("idle_ready", 32'(mem_ready), 32'd0);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_clear();
    qa.delete();
    qd.delete();
    ovf_m  = 1'b0;
    berr_m = 1'b0;
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    model_clear();
    tick();
    tick();
    resetn = 1'b1;
    tick();
  endtask

  task automatic preload(input int idx, input logic [31:0] d);
    init_we   = 1'b1;
    init_addr = 8'(idx);
    init_data = d;
    tick();
    init_we   = 1'b0;
    mem_m[idx] = d;
  endtask

  task automatic pop_once();
    log_pop = 1'b1;
    tick();
    log_pop = 1'b0;
    if (qa.size() != 0) begin
      void'(qa.pop_front());
      void'(qd.pop_front());
    end
  endtask

  // Called at #1 after a clock edge with the DUT idle.
  task automatic access(input logic [31:0] addr, input logic [31:0] wd, input logic [3:0] ws,
                        input bit pop_now, input bit init_now, input logic [31:0] init_d,
                        output logic [31:0] rd);
    int          idx;
    bit          inr;
    logic [31:0] exp_rd;
    inr = (addr < MW * 4);
    idx = int'((addr >> 2) % MW);
    rd  = 32'h0;
    mem_valid = 1'b1;
    mem_addr  = addr;
    mem_wdata = wd;
    mem_wstrb = ws;
    @(posedge clk);
    in_access = 1'b1;
    for (int j = 0; j <= int'(W) + 1; j++) begin
      #1;
      check("ready_timing", 32'(mem_ready), (j == int'(W)) ? 32'd1 : 32'd0);
      if (j == int'(W)) begin
        exp_rd = inr ? mem_m[idx] : 32'h0;
        rd     = mem_rdata;
        check("mem_rdata", mem_rdata, exp_rd);
        if (pop_now) log_pop = 1'b1;
        if (init_now) begin
          init_we   = 1'b1;
          init_addr = 8'(idx);
          init_data = init_d;
        end
      end
      if (j <= int'(W)) begin
        // Inputs outside IDLE must be ignored.
        mem_valid = 1'($urandom);
        mem_addr  = $urandom;
        mem_wdata = $urandom;
        mem_wstrb = 4'($urandom);
      end
      if (j < int'(W) + 1) @(posedge clk);
    end
    mem_valid = 1'b0;
    log_pop   = 1'b0;
    init_we   = 1'b0;
    if (ws != 4'b0000 && inr) begin
      for (int b = 0; b < 4; b++) begin
        if (ws[b]) mem_m[idx][8*b +: 8] = wd[8*b +: 8];
      end
    end
    if (init_now) mem_m[idx] = init_d;
    if (!inr) berr_m = 1'b1;
    if (pop_now && qa.size() != 0) begin
      void'(qa.pop_front());
      void'(qd.pop_front());
    end
    if (ws != 4'b0000) begin
      if (qa.size() < LD) begin
        qa.push_back(addr);
        qd.push_back(wd);
      end else begin
        ovf_m = 1'b1;
      end
    end
    in_access = 1'b0;
  endtask

  // Reset pulse while a store sits in WAIT.
  task automatic abort_store(input logic [31:0] addr, input logic [31:0] wd);
    mem_valid = 1'b1;
    mem_addr  = addr;
    mem_wdata = wd;
    mem_wstrb = 4'hF;
    tick();
    resetn    = 1'b0;
    mem_valid = 1'b0;
    model_clear();
    tick();
    check("abort_ready", 32'(mem_ready), 32'd0);
    tick();
    resetn = 1'b1;
    tick();
  endtask

  logic [31:0] rd;
  logic [31:0] a;
  int          op;

  initial begin
    resetn    = 1'b0;
    mem_valid = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_wstrb = '0;
    init_we   = 1'b0;
    init_addr = '0;
    init_data = '0;
    log_pop   = 1'b0;
    in_access = 1'b0;
    model_clear();
    cmp_en = 1'b1;
    tick();
    tick();
    check("rst_mem_ready", 32'(mem_ready), 32'd0);
    check("rst_mem_rdata", mem_rdata, 32'd0);
    check("rst_log_valid", 32'(log_valid), 32'd0);
    check("rst_log_count", 32'(log_count), 32'd0);
    check("rst_log_addr", log_addr, 32'd0);
    check("rst_log_data", log_data, 32'd0);
    check("rst_overflow", 32'(log_overflow), 32'd0);
    check("rst_bus_err", 32'(bus_err), 32'd0);
    resetn = 1'b1;
    tick();

    for (int i = 0; i < int'(MW); i++) preload(i, $urandom);

    // Fetch of a preloaded instruction
    preload(0, 32'h0000_0093);
    access(32'h0, 32'h0, 4'b0000, 1'b0, 1'b0, 32'h0, rd);
    check("t1_fetch", rd, 32'h0000_0093);

    // Byte-strobed store then read back
    preload(22, 32'h1122_3344);
    access(32'h58, 32'hDEAD_BEEF, 4'b0101, 1'b0, 1'b0, 32'h0, rd);
    check("t2_store_old", rd, 32'h1122_3344);
    check("t2_log_valid", 32'(log_valid), 32'd1);
    check("t2_log_addr", log_addr, 32'h58);
    check("t2_log_data", log_data, 32'hDEAD_BEEF);
    check("t2_log_count", 32'(log_count), 32'd1);
    access(32'h58, 32'h0, 4'b0000, 1'b0, 1'b0, 32'h0, rd);
    check("t2_readback", rd, 32'h11AD_33EF);

    // Out-of-range read
    access(32'h400, 32'h0, 4'b0000, 1'b0, 1'b0, 32'h0, rd);
    check("t3_oor_rdata", rd, 32'h0);
    check("t3_bus_err", 32'(bus_err), 32'd1);
    access(32'h0, 32'h0, 4'b0000, 1'b0, 1'b0, 32'h0, rd);
    check("t3_word0", rd, 32'h0000_0093);
    check("t3_bus_err_sticky", 32'(bus_err), 32'd1);

    // Overflow: nine stores, no pops
    do_reset();
    for (int i = 0; i < 9; i++) access(32'h58 + 32'(4 * i), $urandom, 4'hF, 1'b0, 1'b0, 32'h0, rd);
    check("t4_count", 32'(log_count), 32'd8);
    check("t4_overflow", 32'(log_overflow), 32'd1);
    for (int i = 0; i < 8; i++) begin
      check("t4_pop_addr", log_addr, 32'h58 + 32'(4 * i));
      pop_once();
    end
    check("t4_empty", 32'(log_valid), 32'd0);

    // Full log with a pop on the push edge
    do_reset();
    for (int i = 0; i < 8; i++) access(32'h100 + 32'(4 * i), $urandom, 4'hF, 1'b0, 1'b0, 32'h0, rd);
    access(32'h200, 32'hCAFE_F00D, 4'hF, 1'b1, 1'b0, 32'h0, rd);
    check("t5_count", 32'(log_count), 32'd8);
    check("t5_overflow", 32'(log_overflow), 32'd0);
    for (int i = 0; i < 7; i++) pop_once();
    check("t5_last_addr", log_addr, 32'h200);
    check("t5_last_data", log_data, 32'hCAFE_F00D);
    pop_once();

    // Reset during WAIT of a store
    abort_store(32'h60, 32'h5555_AAAA);
    check("t6_count", 32'(log_count), 32'd0);
    access(32'h60, 32'h0, 4'b0000, 1'b0, 1'b0, 32'h0, rd);
    check("t6_word_unchanged", rd, mem_m[24]);
    access(32'h0, 32'h0, 4'b0000, 1'b0, 1'b0, 32'h0, rd);
    check("t6_fetch", rd, 32'h0000_0093);

    // Preload colliding with a store to the same word
    access(32'h80, 32'hFFFF_FFFF, 4'hF, 1'b0, 1'b1, 32'h1234_5678, rd);
    access(32'h80, 32'h0, 4'b0000, 1'b0, 1'b0, 32'h0, rd);
    check("t7_init_wins", rd, 32'h1234_5678);

    // Randomized traffic
    for (int n = 0; n < 400; n++) begin
      op = int'($urandom_range(0, 99));
      if (op < 70) begin
        if ($urandom_range(0, 9) == 0) a = $urandom_range(1024, 8191);
        else                           a = $urandom_range(0, 1023);
        access(a, $urandom, ($urandom_range(0, 1) == 0) ? 4'b0000 : 4'($urandom),
               ($urandom_range(0, 3) == 0), ($urandom_range(0, 9) == 0), $urandom, rd);
      end else if (op < 88) begin
        pop_once();
      end else if (op < 98) begin
        preload(int'($urandom_range(0, MW - 1)), $urandom);
      end else begin
        abort_store($urandom_range(0, 1023), $urandom);
      end
    end

    cmp_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
